// File: rtl/retire_unit_pkg.sv
// Shared definitions for the retirement stage: ROB head field positions,
// default register-file geometry and the retire FSM encoding.
package retire_unit_pkg;

  localparam int PHYS_DEPTH_DEF = 6;
  localparam int ARCH_DEPTH_DEF = 32;

  // Head entry layout matches what rename pushes into the ROB.
  localparam int PHYS_DEST_LSB  = 87;
  localparam int ARCH_DEST_LSB  = 34;
  localparam int ARCH_DEST_W    = 5;
  localparam int DEST_REQD_BIT  = 149;
  localparam int TARGET_LSB     = 151;
  localparam int TARGET_W       = 32;
  localparam int MISPRED_BIT    = 183;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } retState_e;

endpackage

// File: rtl/retire_rat.sv
// Retirement RAT: committed arch->phys mapping, identity after reset,
// one write port, one read port and a flat view for rename recovery.
module retire_rat
  import retire_unit_pkg::*;
#(
  parameter int PHYS_W   = PHYS_DEPTH_DEF,
  parameter int NUM_ARCH = ARCH_DEPTH_DEF,
  parameter int AW       = $clog2(NUM_ARCH)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       wrEn,
  input  logic [AW-1:0]              wrAddr,
  input  logic [PHYS_W-1:0]          wrData,
  input  logic [AW-1:0]              rdAddr,
  output logic [PHYS_W-1:0]          rdData,
  output logic [NUM_ARCH*PHYS_W-1:0] ratPacked
);

  logic [NUM_ARCH-1:0][PHYS_W-1:0] rat;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_ARCH; i++) rat[i] <= PHYS_W'(i);
    end else if (wrEn) begin
      rat[wrAddr] <= wrData;
    end
  end

  // Read is pre-write, so a retiring instruction frees the mapping it replaces.
  assign rdData    = rat[rdAddr];
  assign ratPacked = rat;

endmodule

// File: rtl/retire_unit.sv
// In-order retirement: pops the ROB head when done, frees the superseded
// physical tag, and on a mispredict flushes and restores the rename RAT.
module retire_unit
  import retire_unit_pkg::*;
#(
  parameter int PHYSREGS_DEPTH = PHYS_DEPTH_DEF,
  parameter int ARCHREGS_DEPTH = ARCH_DEPTH_DEF,
  parameter int ROB_DATAWIDTH  = 184,
  parameter int ROB_ADDRWIDTH  = 6
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic                                 FREEZE,
  input  logic                                 fROB_empty_IN,
  input  logic                                 fROB_headDone_IN,
  input  logic [ROB_DATAWIDTH-1:0]             fROB_headData_IN,
  output logic                                 tROB_popReq_OUT,
  input  logic                                 fFreeL_full_IN,
  output logic                                 tFreeL_pushReq_OUT,
  output logic [PHYSREGS_DEPTH-1:0]            tFreeL_pushData_OUT,
  output logic                                 tRenRatOverwrite_OUT,
  output logic [PHYSREGS_DEPTH*ARCHREGS_DEPTH-1:0] tRenRatOverwriteData_OUT,
  output logic                                 tFlush_OUT,
  output logic [31:0]                          tRedirectPC_OUT,
  output logic [31:0]                          tRetireCount_OUT
);

  localparam int AW = $clog2(ARCHREGS_DEPTH);

  if (ROB_DATAWIDTH <= MISPRED_BIT || ROB_ADDRWIDTH < 1) begin : gBadCfg
    $error("retire_unit: ROB entry too narrow for head field layout");
  end

  retState_e state, stateNext;

  logic [PHYSREGS_DEPTH-1:0] physDest, ratRdData;
  logic [ARCH_DEST_W-1:0]    archDest;
  logic [TARGET_W-1:0]       targetPc;
  logic                      destReqd, mispredict, retire, ratWe, archIsZero;
  logic                      unusedHeadBits;

  assign physDest   = fROB_headData_IN[PHYS_DEST_LSB +: PHYSREGS_DEPTH];
  assign archDest   = fROB_headData_IN[ARCH_DEST_LSB +: ARCH_DEST_W];
  assign targetPc   = fROB_headData_IN[TARGET_LSB +: TARGET_W];
  assign destReqd   = fROB_headData_IN[DEST_REQD_BIT];
  assign mispredict = fROB_headData_IN[MISPRED_BIT];
  assign archIsZero = (archDest == '0);
  assign unusedHeadBits = ^fROB_headData_IN;

  // A destReqd head needs free-list room even for r0, since it pushes physDest.
  assign retire = !RESET && (state == RUN) && !FREEZE && !fROB_empty_IN &&
                  fROB_headDone_IN && (!destReqd || !fFreeL_full_IN);

  assign tROB_popReq_OUT     = retire;
  assign tFreeL_pushReq_OUT  = retire && destReqd;
  assign tFreeL_pushData_OUT = archIsZero ? physDest : ratRdData;
  assign ratWe               = retire && destReqd && !archIsZero;

  retire_rat #(
    .PHYS_W   (PHYSREGS_DEPTH),
    .NUM_ARCH (ARCHREGS_DEPTH),
    .AW       (AW)
  ) uRat (
    .CLK       (CLK),
    .RESET     (RESET),
    .wrEn      (ratWe),
    .wrAddr    (AW'(archDest)),
    .wrData    (physDest),
    .rdAddr    (AW'(archDest)),
    .rdData    (ratRdData),
    .ratPacked (tRenRatOverwriteData_OUT)
  );

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (retire && mispredict) stateNext = FLUSH;
      FLUSH:   stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state                <= RUN;
      tRetireCount_OUT     <= '0;
      tFlush_OUT           <= 1'b0;
      tRenRatOverwrite_OUT <= 1'b0;
      tRedirectPC_OUT      <= '0;
    end else begin
      state                <= stateNext;
      tFlush_OUT           <= (stateNext == FLUSH);
      tRenRatOverwrite_OUT <= (stateNext == FLUSH);
      if (retire) tRetireCount_OUT <= tRetireCount_OUT + 32'd1;
      if (retire && mispredict) tRedirectPC_OUT <= targetPc;
    end
  end

endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_retire_unit;

  logic         CLK, RESET, FREEZE, robEmpty, robDone, freeFull;
  logic [183:0] headData;
  logic         popReq, pushReq, ovw, flush;
  logic [5:0]   pushData;
  logic [191:0] ratData;
  logic [31:0]  redirPc, retCnt;

  typedef struct {
    logic        pop;
    logic        push;
    logic [5:0]  pd;
    logic        fl;
    logic        ov;
    logic [31:0] rd;
    logic [31:0] cnt;
    int          ratIdx;
    logic [5:0]  ratVal;
    bit          ident;
  } exp_t;

  exp_t sbQ[$];
  int   passCnt = 0;
  int   totalCnt = 0;
  logic [191:0] identRat;

  retire_unit dut (
    .CLK                      (CLK),
    .RESET                    (RESET),
    .FREEZE                   (FREEZE),
    .fROB_empty_IN            (robEmpty),
    .fROB_headDone_IN         (robDone),
    .fROB_headData_IN         (headData),
    .tROB_popReq_OUT          (popReq),
    .fFreeL_full_IN           (freeFull),
    .tFreeL_pushReq_OUT       (pushReq),
    .tFreeL_pushData_OUT      (pushData),
    .tRenRatOverwrite_OUT     (ovw),
    .tRenRatOverwriteData_OUT (ratData),
    .tFlush_OUT               (flush),
    .tRedirectPC_OUT          (redirPc),
    .tRetireCount_OUT         (retCnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [183:0] mkHead(input logic dr, input logic [4:0] a,
                                          input logic [5:0] p, input logic [31:0] t,
                                          input logic mp);
    logic [183:0] h;
    h = '0;
    h[149] = dr;
    h[38:34] = a;
    h[92:87] = p;
    h[182:151] = t;
    h[183] = mp;
    return h;
  endfunction

  function automatic exp_t mkExp(input logic pop, push, input logic [5:0] pd,
                                 input logic fl, ov, input logic [31:0] rd, cnt,
                                 input int ri, input logic [5:0] rv, input bit id);
    exp_t e;
    e.pop = pop; e.push = push; e.pd = pd; e.fl = fl; e.ov = ov;
    e.rd = rd; e.cnt = cnt; e.ratIdx = ri; e.ratVal = rv; e.ident = id;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] expv);
    totalCnt++;
    if (act === expv) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  task automatic step(input logic rst, fz, emp, dn, full, input logic [183:0] hd,
                      input exp_t e);
    RESET = rst; FREEZE = fz; robEmpty = emp; robDone = dn; freeFull = full;
    headData = hd;
    sbQ.push_back(e);
    @(posedge CLK); #1;
  endtask

  // Monitor: one expectation record per driven cycle.
  always @(negedge CLK) begin
    if (sbQ.size() > 0) begin
      exp_t e;
      e = sbQ.pop_front();
      chk("pop", {191'b0, popReq}, {191'b0, e.pop});
      chk("push", {191'b0, pushReq}, {191'b0, e.push});
      if (e.push) chk("pushData", {186'b0, pushData}, {186'b0, e.pd});
      chk("flush", {191'b0, flush}, {191'b0, e.fl});
      chk("overwrite", {191'b0, ovw}, {191'b0, e.ov});
      chk("redirect", {160'b0, redirPc}, {160'b0, e.rd});
      chk("count", {160'b0, retCnt}, {160'b0, e.cnt});
      if (e.ratIdx >= 0)
        chk($sformatf("rat[%0d]", e.ratIdx), {186'b0, ratData[e.ratIdx*6 +: 6]}, {186'b0, e.ratVal});
      if (e.ident) chk("ratIdentity", ratData, identRat);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [183:0] h1, h0, hNd, hMp1, h3, hMp2, hZ;
    for (int i = 0; i < 32; i++) identRat[i*6 +: 6] = 6'(i);
    h1   = mkHead(1'b1, 5'd5, 6'd40, 32'h0, 1'b0);
    h0   = mkHead(1'b1, 5'd0, 6'd33, 32'h0, 1'b0);
    hNd  = mkHead(1'b0, 5'd7, 6'd9, 32'h0, 1'b0);
    hMp1 = mkHead(1'b1, 5'd2, 6'd50, 32'h0040_0100, 1'b1);
    h3   = mkHead(1'b1, 5'd3, 6'd20, 32'h0, 1'b0);
    hMp2 = mkHead(1'b1, 5'd4, 6'd60, 32'h0000_1234, 1'b1);
    hZ   = '0;

    RESET = 1'b1; FREEZE = 1'b0; robEmpty = 1'b1; robDone = 1'b0;
    freeFull = 1'b0; headData = '0;
    @(posedge CLK); #1;

    //   rst fz emp dn full head   pop push pd   fl ov redirect      cnt  ratIdx val ident
    step(1, 0, 0, 1, 0, h1,   mkExp(0, 0, 6'd0,  0, 0, 32'h0,        0, -1, 6'd0,  1));
    step(0, 0, 1, 0, 0, hZ,   mkExp(0, 0, 6'd0,  0, 0, 32'h0,        0, -1, 6'd0,  1));
    step(0, 0, 0, 1, 0, h1,   mkExp(1, 1, 6'd5,  0, 0, 32'h0,        0,  5, 6'd5,  0));
    step(0, 0, 0, 1, 1, h1,   mkExp(0, 0, 6'd0,  0, 0, 32'h0,        1,  5, 6'd40, 0));
    step(0, 0, 0, 1, 1, h1,   mkExp(0, 0, 6'd0,  0, 0, 32'h0,        1,  5, 6'd40, 0));
    step(0, 0, 0, 1, 1, h1,   mkExp(0, 0, 6'd0,  0, 0, 32'h0,        1,  5, 6'd40, 0));
    step(0, 0, 0, 1, 0, h1,   mkExp(1, 1, 6'd40, 0, 0, 32'h0,        1,  5, 6'd40, 0));
    step(0, 0, 0, 1, 0, h0,   mkExp(1, 1, 6'd33, 0, 0, 32'h0,        2,  5, 6'd40, 0));
    step(0, 0, 0, 0, 0, h0,   mkExp(0, 0, 6'd0,  0, 0, 32'h0,        3,  0, 6'd0,  0));
    step(0, 0, 0, 1, 0, hNd,  mkExp(1, 0, 6'd0,  0, 0, 32'h0,        3, -1, 6'd0,  0));
    step(0, 0, 0, 1, 0, hMp1, mkExp(1, 1, 6'd2,  0, 0, 32'h0,        4,  2, 6'd2,  0));
    step(0, 1, 0, 1, 0, h3,   mkExp(0, 0, 6'd0,  1, 1, 32'h0040_0100, 5, 2, 6'd50, 0));
    step(0, 1, 0, 1, 0, h3,   mkExp(0, 0, 6'd0,  0, 0, 32'h0040_0100, 5, 3, 6'd3,  0));
    step(0, 0, 0, 1, 0, h3,   mkExp(1, 1, 6'd3,  0, 0, 32'h0040_0100, 5, 3, 6'd3,  0));
    step(0, 0, 0, 1, 0, hMp2, mkExp(1, 1, 6'd4,  0, 0, 32'h0040_0100, 6, 3, 6'd20, 0));
    step(1, 0, 0, 1, 0, h3,   mkExp(0, 0, 6'd0,  1, 1, 32'h0000_1234, 7, 4, 6'd60, 0));
    step(0, 0, 1, 0, 0, hZ,   mkExp(0, 0, 6'd0,  0, 0, 32'h0,        0, -1, 6'd0,  1));
    step(0, 0, 1, 0, 0, hZ,   mkExp(0, 0, 6'd0,  0, 0, 32'h0,        0, -1, 6'd0,  1));

    chk("scoreboardDrained", 192'(sbQ.size()), 192'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/retire_unit.md
RETIRE_UNIT -- requirements
Module: retire_unit

Interface
REQ-001 Parameter: PHYSREGS_DEPTH, default 6, physical register tag width.
REQ-002 Parameter: ARCHREGS_DEPTH, default 32, number of architectural registers.
REQ-003 Parameter: ROB_DATAWIDTH, default 184, width of one ROB entry.
REQ-004 Parameter: ROB_ADDRWIDTH, default 6, ROB index width.
REQ-005 One clock, CLK; reset is RESET, synchronous and active-high.
REQ-006 Port CLK, input, 1, clock.
REQ-007 Port RESET, input, 1, synchronous active-high reset.
REQ-008 Port FREEZE, input, 1, global stall; no retirement while high.
REQ-009 Port fROB_empty_IN, input, 1, ROB has no entries.
REQ-010 Port fROB_headDone_IN, input, 1, head entry has completed execution.
REQ-011 Port fROB_headData_IN, input, ROB_DATAWIDTH, head entry contents.
REQ-012 Port tROB_popReq_OUT, output, 1, retire (pop) head this cycle.
REQ-013 Port fFreeL_full_IN, input, 1, free list cannot accept a push.
REQ-014 Port tFreeL_pushReq_OUT, output, 1, return a tag to the free list.
REQ-015 Port tFreeL_pushData_OUT, output, PHYSREGS_DEPTH, returned tag.
REQ-016 Port tRenRatOverwrite_OUT, output, 1, rename RAT must load the retirement RAT.
REQ-017 Port tRenRatOverwriteData_OUT, output, PHYSREGS_DEPTH*ARCHREGS_DEPTH, packed retirement RAT; entry i occupies bits [6i+5:6i].
REQ-018 Port tFlush_OUT, output, 1, squash all younger work (queues, ROB).
REQ-019 Port tRedirectPC_OUT, output, 32, fetch restart PC, valid with tFlush_OUT.
REQ-020 Port tRetireCount_OUT, output, 32, count of retired instructions.

Function
REQ-021 Head field layout, identical to the rename push: physDest [92:87], archDest [38:34], destReqd [149], target PC [182:151], mispredict [183].
REQ-022 Retirement RAT (RRAT): ARCHREGS_DEPTH entries of PHYSREGS_DEPTH bits each.
REQ-023 FSM states: RUN and FLUSH.
REQ-024 Retire condition in RUN: !FREEZE && !fROB_empty_IN && fROB_headDone_IN && (!destReqd || !fFreeL_full_IN).
REQ-025 tROB_popReq_OUT is combinational and equals the retire condition; at most one retirement per cycle.
REQ-026 On retire with destReqd and archDest != 0: push RRAT[archDest] to the free list the same cycle (combinational), and RRAT[archDest] <= physDest at the clock edge.
REQ-027 On retire with destReqd and archDest == 0: push physDest, and leave the RRAT unchanged.
REQ-028 On retire with !destReqd: no push.
REQ-029 tRetireCount_OUT increments by 1 per retirement, wrapping at 2^32.
REQ-030 Retire with mispredict=1: the RRAT update still occurs, tRedirectPC_OUT <= target, and the next state is FLUSH.
REQ-031 FLUSH lasts exactly one cycle: tFlush_OUT=1, tRenRatOverwrite_OUT=1, tRenRatOverwriteData_OUT = RRAT including that cycle's update; the next state is RUN.
REQ-032 tFlush_OUT, tRenRatOverwrite_OUT and tRedirectPC_OUT are registered; tRenRatOverwriteData_OUT is continuously driven from the RRAT.
REQ-033 No pop and no push occur in FLUSH, regardless of the other inputs.
REQ-034 FREEZE high in the FLUSH cycle does not extend or suppress the flush.
REQ-035 fROB_headDone_IN low with a non-empty ROB produces no pop.
REQ-036 Free list full on a destReqd head stalls without pop or push; the next cycle is retried.

Reset
REQ-037 While RESET is high: state=RUN, RRAT[i]=i, tRetireCount_OUT=0, tFlush_OUT=0, tRenRatOverwrite_OUT=0, tRedirectPC_OUT=0.
REQ-038 While RESET is high: tROB_popReq_OUT=0 and tFreeL_pushReq_OUT=0.
REQ-039 RESET asserted in FLUSH abandons the flush; outputs take reset values on the next edge.

Structure
REQ-040 Shared package: ROB field bit positions, PHYSREGS_DEPTH/ARCHREGS_DEPTH defaults, FSM state encoding.
REQ-041 One sub-module, retire_rat: RRAT storage with one write port, one read port, identity reset and packed output.

Verification
REQ-042 Reset, then idle: RRAT packed output = {31,...,1,0}, and all pops and pushes are 0.
REQ-043 Head done, destReqd=1, archDest=5, physDest=40 -> pop=1, push=1 with data 5, then RRAT[5]=40 and count=1.
REQ-044 Same head with fFreeL_full_IN=1 for 3 cycles -> no pop or push for 3 cycles; retires on the cycle full drops.
REQ-045 Head archDest=0, physDest=33 -> push of 33; RRAT[0] remains 0.
REQ-046 Mispredict head, archDest=2, physDest=50, target=0x400100 -> next cycle tFlush=1, overwrite=1, data bits [17:12]=50, redirect=0x400100; no pop that cycle.
REQ-047 FREEZE=1 with a done head -> no pop; RESET asserted during FLUSH -> all outputs at reset values the next cycle.
